// File: rtl/triangle_list_sequencer.sv
// triangle_list_sequencer: double-buffered host triangle list issued to the rasterizer one triangle per go/done handshake.
// Ports: i_clk, srst_n (sync, active-low); host i_reg_addr/i_reg_write_en/i_reg_write_data -> o_reg_read_data (1-cycle latency);
//   i_new_frame starts a list; o_tri_go/i_tri_done handshake; o_p*_x/o_p*_y/o_color triangle; o_busy; o_frame_done.
// Build option: define TRI_CLAMP_EN to clamp x/y writes to the screen range instead of truncating.
module triangle_list_sequencer #(
  parameter int NUM_TRIANGLES = 8,
  parameter int HORIZ_RESOLUTION = 80,
  parameter int VERT_RESOLUTION = 60,
  parameter int COLOR_DEPTH = 12,
  parameter int REG_WIDTH = 32,
  parameter int ADDR_WIDTH = $clog2(NUM_TRIANGLES*8)+1
)(
  input  logic i_clk,
  input  logic srst_n,
  input  logic [ADDR_WIDTH-1:0] i_reg_addr,
  input  logic i_reg_write_en,
  input  logic [REG_WIDTH-1:0] i_reg_write_data,
  output logic [REG_WIDTH-1:0] o_reg_read_data,
  input  logic i_new_frame,
  output logic o_tri_go,
  input  logic i_tri_done,
  output logic [$clog2(HORIZ_RESOLUTION)-1:0] o_p0_x,
  output logic [$clog2(VERT_RESOLUTION)-1:0] o_p0_y,
  output logic [$clog2(HORIZ_RESOLUTION)-1:0] o_p1_x,
  output logic [$clog2(VERT_RESOLUTION)-1:0] o_p1_y,
  output logic [$clog2(HORIZ_RESOLUTION)-1:0] o_p2_x,
  output logic [$clog2(VERT_RESOLUTION)-1:0] o_p2_y,
  output logic [COLOR_DEPTH-1:0] o_color,
  output logic o_busy,
  output logic o_frame_done
);
  localparam int XW = $clog2(HORIZ_RESOLUTION);
  localparam int YW = $clog2(VERT_RESOLUTION);
  localparam int IW = NUM_TRIANGLES > 1 ? $clog2(NUM_TRIANGLES) : 1;
  localparam int CW = $clog2(NUM_TRIANGLES+1);
  localparam int LW = ADDR_WIDTH-1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state;
  logic [XW-1:0] x_mem [2][NUM_TRIANGLES][3];
  logic [YW-1:0] y_mem [2][NUM_TRIANGLES][3];
  logic [COLOR_DEPTH-1:0] c_mem [2][NUM_TRIANGLES];
  logic bank_sel, pending, overrun;
  logic [CW-1:0] sh_cnt, act_cnt, ncnt, wcnt;
  logic [IW-1:0] idx, ti, ld_i;
  logic [LW-1:0] low, toff;
  logic [2:0] fld;
  logic ctrl, t_ok, swap, ld_b, set_p, clr_o;
  logic [XW-1:0] wx;
  logic [YW-1:0] wy;
  logic [REG_WIDTH-1:0] rd;
  assign ctrl = i_reg_addr[ADDR_WIDTH-1];
  assign low = i_reg_addr[LW-1:0];
  assign fld = i_reg_addr[2:0];
  assign toff = low >> 3;
  assign ti = toff[IW-1:0];
  assign t_ok = toff < LW'(NUM_TRIANGLES);
`ifdef TRI_CLAMP_EN
  assign wx = i_reg_write_data > REG_WIDTH'(HORIZ_RESOLUTION-1) ? XW'(HORIZ_RESOLUTION-1) : i_reg_write_data[XW-1:0];
  assign wy = i_reg_write_data > REG_WIDTH'(VERT_RESOLUTION-1) ? YW'(VERT_RESOLUTION-1) : i_reg_write_data[YW-1:0];
`else
  assign wx = i_reg_write_data[XW-1:0];
  assign wy = i_reg_write_data[YW-1:0];
`endif
  assign wcnt = i_reg_write_data > REG_WIDTH'(NUM_TRIANGLES) ? CW'(NUM_TRIANGLES) : i_reg_write_data[CW-1:0];
  assign set_p = i_reg_write_en && ctrl && low == LW'(0) && i_reg_write_data[0];
  assign clr_o = i_reg_write_en && ctrl && low == LW'(3) && i_reg_write_data[3];
  assign swap = state == IDLE && i_new_frame && pending;
  assign ncnt = swap ? sh_cnt : act_cnt;
  // Triangle to present on entering ISSUE: slot 0 of the (possibly just swapped) bank at list start, else the next slot.
  assign ld_b = state == IDLE ? bank_sel ^ swap : bank_sel;
  assign ld_i = state == IDLE ? '0 : idx + IW'(1);
  always_comb begin
    rd = '0;
    if (ctrl)
      rd = low == LW'(0) ? REG_WIDTH'(pending) :
           low == LW'(1) ? REG_WIDTH'(sh_cnt) :
           low == LW'(2) ? REG_WIDTH'({overrun, o_busy, bank_sel, pending}) : '0;
    else if (t_ok)
      rd = fld == 3'd6 ? REG_WIDTH'(c_mem[~bank_sel][ti]) :
           fld == 3'd7 ? '0 :
           fld[0] ? REG_WIDTH'(y_mem[~bank_sel][ti][fld[2:1]]) : REG_WIDTH'(x_mem[~bank_sel][ti][fld[2:1]]);
  end
  always_ff @(posedge i_clk) begin
    if (!srst_n) begin
      for (int b = 0; b < 2; b++)
        for (int t = 0; t < NUM_TRIANGLES; t++) begin
          c_mem[b][t] <= '0;
          for (int v = 0; v < 3; v++) begin
            x_mem[b][t][v] <= '0;
            y_mem[b][t][v] <= '0;
          end
        end
      state <= IDLE;
      bank_sel <= 1'b0;
      pending <= 1'b0;
      overrun <= 1'b0;
      sh_cnt <= '0;
      act_cnt <= '0;
      idx <= '0;
      o_reg_read_data <= '0;
      o_tri_go <= 1'b0;
      o_busy <= 1'b0;
      o_frame_done <= 1'b0;
      {o_p0_x, o_p0_y, o_p1_x, o_p1_y, o_p2_x, o_p2_y, o_color} <= '0;
    end else begin
      o_reg_read_data <= rd;
      if (i_reg_write_en && !ctrl && t_ok) begin
        if (fld == 3'd6) c_mem[~bank_sel][ti] <= i_reg_write_data[COLOR_DEPTH-1:0];
        else if (fld != 3'd7 && fld[0]) y_mem[~bank_sel][ti][fld[2:1]] <= wy;
        else if (fld != 3'd7) x_mem[~bank_sel][ti][fld[2:1]] <= wx;
      end
      if (i_reg_write_en && ctrl && low == LW'(1)) sh_cnt <= wcnt;
      // A CTRL write landing on the swap cycle survives the clear and arms the next frame.
      pending <= (pending && !swap) || set_p;
      overrun <= (i_new_frame && state != IDLE) || (overrun && !clr_o);
      if ((state == IDLE && i_new_frame && ncnt != '0) || (state == WAIT && i_tri_done && CW'(idx) + CW'(1) != act_cnt)) begin
        o_p0_x <= x_mem[ld_b][ld_i][0];
        o_p0_y <= y_mem[ld_b][ld_i][0];
        o_p1_x <= x_mem[ld_b][ld_i][1];
        o_p1_y <= y_mem[ld_b][ld_i][1];
        o_p2_x <= x_mem[ld_b][ld_i][2];
        o_p2_y <= y_mem[ld_b][ld_i][2];
        o_color <= c_mem[ld_b][ld_i];
      end
      case (state)
        IDLE: if (i_new_frame) begin
          bank_sel <= ld_b;
          act_cnt <= ncnt;
          idx <= '0;
          o_busy <= 1'b1;
          state <= ncnt == '0 ? DONE : ISSUE;
          o_frame_done <= ncnt == '0;
          o_tri_go <= ncnt != '0;
        end
        ISSUE: begin
          state <= WAIT;
          o_tri_go <= 1'b0;
        end
        WAIT: if (i_tri_done) begin
          if (CW'(idx) + CW'(1) == act_cnt) begin
            state <= DONE;
            o_frame_done <= 1'b1;
          end else begin
            state <= ISSUE;
            idx <= ld_i;
            o_tri_go <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          o_frame_done <= 1'b0;
          o_busy <= 1'b0;
        end
      endcase
    end
  end
endmodule
